// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the GMII transmit MAC.
// Also holds the byte-wide reflected CRC-32 step used by eth_crc32.
package eth_tx_pkg;

   typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} txState_t;

   localparam int               LEN_W         = 11;
   localparam logic [7:0]       PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]       SFD_BYTE      = 8'hD5;
   localparam logic [LEN_W-1:0] PREAMBLE_LEN  = 11'd7;
   localparam logic [LEN_W-1:0] MIN_PAYLOAD   = 11'd60;
   localparam logic [31:0]      CRC_POLY      = 32'hEDB88320;
   localparam logic [31:0]      CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [7:0]       CTRL_ADDR     = 8'hFF;

   function automatic logic [31:0] crc32Byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_tx_mac_if.sv
// Command/buffer write port and GMII transmit outputs of eth_tx_mac.
// The master side is the CPU/bench, the slave side is the MAC.
interface eth_tx_mac_if;

   logic        i_cmd_wr;
   logic [7:0]  i_cmd_addr;
   logic [31:0] i_cmd_data;
   logic [7:0]  o_tx_data;
   logic        o_tx_en;
   logic        o_busy;
   logic        o_irq_tx;

   modport master (
      output i_cmd_wr, i_cmd_addr, i_cmd_data,
      input  o_tx_data, o_tx_en, o_busy, o_irq_tx
   );

   modport slave (
      input  i_cmd_wr, i_cmd_addr, i_cmd_data,
      output o_tx_data, o_tx_en, o_busy, o_irq_tx
   );

endinterface

// File: rtl/eth_crc32.sv
// Registered byte-wide IEEE 802.3 CRC-32 accumulator.
// Init has priority over en; the result appears the cycle after en.
module eth_crc32
   import eth_tx_pkg::*;
(
   input  logic        i_clk,
   input  logic        rst_n,
   input  logic        i_init,
   input  logic        i_en,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] r_crc;

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_crc <= CRC_INIT;
      end else if (i_init) begin
         r_crc <= CRC_INIT;
      end else if (i_en) begin
         r_crc <= crc32Byte(r_crc, i_data);
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/eth_tx_mac.sv
// GMII byte transmit MAC: preamble, SFD, buffered payload, zero pad, FCS and IFG.
// Every output is registered; the FSM state names the byte currently on o_tx_data.
module eth_tx_mac
   import eth_tx_pkg::*;
#(
   parameter int BUF_WORDS = 128,
   parameter int IFG_BYTES = 12
) (
   input  logic        i_tx_clk,
   input  logic        rst_n,
   eth_tx_mac_if.slave bus
);

   localparam int               ADDR_W   = $clog2(BUF_WORDS);
   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(BUF_WORDS * 4);
   localparam logic [LEN_W-1:0] IFG_LAST = LEN_W'(IFG_BYTES - 1);

   logic [31:0]      r_mem [BUF_WORDS];
   logic [31:0]      r_rdWord;
   txState_t         r_state, w_nextState;
   logic [LEN_W-1:0] r_cnt, w_nextCnt, w_cntInc;
   logic [LEN_W-1:0] r_len;
   logic [7:0]       r_txData, w_nextTxData;
   logic             r_txEn, w_nextTxEn;
   logic             r_busy, w_nextBusy;
   logic             r_irq, w_nextIrq;
   logic             w_bufWr, w_start, w_crcInit, w_crcEn;
   logic [LEN_W-1:0] w_cmdLen, w_aheadIdx;
   logic [ADDR_W-1:0] w_rdAddr;
   logic [1:0]       w_byteSel, w_fcsSel;
   logic [7:0]       w_bufByte, w_fcsByte;
   logic [31:0]      w_crc, w_crcInv;

   assign w_bufWr  = bus.i_cmd_wr && ({1'b0, bus.i_cmd_addr} < 9'(BUF_WORDS));
   assign w_cmdLen = bus.i_cmd_data[LEN_W-1:0];
   assign w_start  = bus.i_cmd_wr && (bus.i_cmd_addr == CTRL_ADDR) && (r_state == IDLE)
                     && (w_cmdLen != '0) && (w_cmdLen <= MAX_LEN);

   // Read two bytes ahead so the RAM latency is hidden and DATA bytes stay contiguous
   assign w_aheadIdx = (r_state == DATA) ? r_cnt + 11'd2 : '0;
   assign w_rdAddr   = ADDR_W'(w_aheadIdx >> 2);

   always_ff @(posedge i_tx_clk) begin
      if (w_bufWr) begin
         r_mem[bus.i_cmd_addr[ADDR_W-1:0]] <= bus.i_cmd_data;
      end
      r_rdWord <= r_mem[w_rdAddr];
   end

   assign w_cntInc  = r_cnt + 11'd1;
   assign w_byteSel = (r_state == SFD) ? 2'd0 : w_cntInc[1:0];
   assign w_bufByte = r_rdWord[{w_byteSel, 3'b000} +: 8];
   assign w_fcsSel  = (r_state == FCS) ? w_cntInc[1:0] : 2'd0;
   assign w_crcInv  = ~w_crc;
   assign w_fcsByte = w_crcInv[{w_fcsSel, 3'b000} +: 8];

   always_comb begin
      w_nextState  = r_state;
      w_nextCnt    = r_cnt;
      w_nextTxData = '0;
      w_nextTxEn   = 1'b0;
      w_nextBusy   = 1'b0;
      w_nextIrq    = 1'b0;
      w_crcInit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_nextState  = PREAMBLE;
               w_nextCnt    = '0;
               w_nextTxData = PREAMBLE_BYTE;
               w_nextTxEn   = 1'b1;
               w_nextBusy   = 1'b1;
               w_crcInit    = 1'b1;
            end
         end
         PREAMBLE: begin
            w_nextTxEn = 1'b1;
            w_nextBusy = 1'b1;
            if (r_cnt == PREAMBLE_LEN - 11'd1) begin
               w_nextState  = SFD;
               w_nextCnt    = '0;
               w_nextTxData = SFD_BYTE;
            end else begin
               w_nextCnt    = w_cntInc;
               w_nextTxData = PREAMBLE_BYTE;
            end
         end
         SFD: begin
            w_nextState  = DATA;
            w_nextCnt    = '0;
            w_nextTxData = w_bufByte;
            w_nextTxEn   = 1'b1;
            w_nextBusy   = 1'b1;
         end
         DATA: begin
            w_nextTxEn = 1'b1;
            w_nextBusy = 1'b1;
            if (r_cnt != r_len - 11'd1) begin
               w_nextCnt    = w_cntInc;
               w_nextTxData = w_bufByte;
            end else if (r_len < MIN_PAYLOAD) begin
               w_nextState = PAD;
               w_nextCnt   = w_cntInc;
            end else begin
               w_nextState  = FCS;
               w_nextCnt    = '0;
               w_nextTxData = w_fcsByte;
            end
         end
         PAD: begin
            w_nextTxEn = 1'b1;
            w_nextBusy = 1'b1;
            if (r_cnt == MIN_PAYLOAD - 11'd1) begin
               w_nextState  = FCS;
               w_nextCnt    = '0;
               w_nextTxData = w_fcsByte;
            end else begin
               w_nextCnt = w_cntInc;
            end
         end
         FCS: begin
            w_nextBusy = 1'b1;
            if (r_cnt == 11'd3) begin
               w_nextState = IFG;
               w_nextCnt   = '0;
               w_nextIrq   = 1'b1;
            end else begin
               w_nextCnt    = w_cntInc;
               w_nextTxData = w_fcsByte;
               w_nextTxEn   = 1'b1;
            end
         end
         IFG: begin
            if (r_cnt == IFG_LAST) begin
               w_nextState = IDLE;
               w_nextCnt   = '0;
            end else begin
               w_nextCnt  = w_cntInc;
               w_nextBusy = 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
         end
      endcase
   end

   // The CRC tracks every byte about to be driven in DATA/PAD, so it is complete at the FCS edge
   assign w_crcEn = (w_nextState == DATA) || (w_nextState == PAD);

   eth_crc32 u_crc (
      .i_clk  (i_tx_clk),
      .rst_n  (rst_n),
      .i_init (w_crcInit),
      .i_en   (w_crcEn),
      .i_data (w_nextTxData),
      .o_crc  (w_crc)
   );

   always_ff @(posedge i_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_len    <= '0;
         r_txData <= '0;
         r_txEn   <= 1'b0;
         r_busy   <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_cnt    <= w_nextCnt;
         r_txData <= w_nextTxData;
         r_txEn   <= w_nextTxEn;
         r_busy   <= w_nextBusy;
         r_irq    <= w_nextIrq;
         if (w_start) begin
            r_len <= w_cmdLen;
         end
      end
   end

   assign bus.o_tx_data = r_txData;
   assign bus.o_tx_en   = r_txEn;
   assign bus.o_busy    = r_busy;
   assign bus.o_irq_tx  = r_irq;

endmodule
